// File: rtl/aes192dec_stream_arbiter.sv
// Round-robin arbiter that time-shares one AES-192 decrypt core (ap_ctrl_hs) between two
// AXI4-Stream requesters, one block in flight, with per-channel delivered-block counters.
module aes192dec_stream_arbiter #(
    parameter int DW   = 128,
    parameter int KW   = 192,
    parameter int CNTW = 32
) (
    input  logic            ap_clk,
    input  logic            ap_rst,
    input  logic [DW-1:0]   s0_TDATA,
    input  logic            s0_TVALID,
    output logic            s0_TREADY,
    input  logic [DW-1:0]   s1_TDATA,
    input  logic            s1_TVALID,
    output logic            s1_TREADY,
    input  logic [KW-1:0]   key0,
    input  logic [KW-1:0]   key1,
    output logic [DW-1:0]   m0_TDATA,
    output logic            m0_TVALID,
    input  logic            m0_TREADY,
    output logic [DW-1:0]   m1_TDATA,
    output logic            m1_TVALID,
    input  logic            m1_TREADY,
    output logic            core_ap_start,
    input  logic            core_ap_ready,
    input  logic            core_ap_idle,
    output logic [DW-1:0]   core_in_TDATA,
    output logic            core_in_TVALID,
    input  logic            core_in_TREADY,
    output logic [KW-1:0]   core_key,
    input  logic [DW-1:0]   core_out_TDATA,
    input  logic            core_out_TVALID,
    output logic            core_out_TREADY,
    output logic            busy,
    output logic            grant,
    output logic [CNTW-1:0] cnt0,
    output logic [CNTW-1:0] cnt1
);

    typedef enum logic [1:0] {IDLE, SEND, RUN, DELIVER} state_t;

    localparam logic [CNTW-1:0] CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};

    state_t          r_state;
    logic            r_last_grant;
    logic            r_grant;
    logic            r_rdy_seen;
    logic            r_res_seen;
    logic [DW-1:0]   r_blk;
    logic [DW-1:0]   r_res;
    logic [KW-1:0]   r_key;
    logic [CNTW-1:0] r_cnt0;
    logic [CNTW-1:0] r_cnt1;

    logic w_sel;
    logic w_take;
    logic w_out_hs;
    logic w_m_hs;
    logic w_rdy_now;
    logic w_res_now;
    logic w_unused_idle;

    // Idle status from the core is informational only; sequencing relies on ap_ready.
    assign w_unused_idle = core_ap_idle;

    // On contention the channel that did not win last time gets the core.
    assign w_sel  = (s0_TVALID & s1_TVALID) ? ~r_last_grant : s1_TVALID;
    assign w_take = (r_state == IDLE) & ~ap_rst & (s0_TVALID | s1_TVALID);

    assign s0_TREADY = w_take & ~w_sel;
    assign s1_TREADY = w_take & w_sel;

    assign core_ap_start   = (r_state == SEND) | ((r_state == RUN) & ~r_rdy_seen);
    assign core_in_TVALID  = (r_state == SEND);
    assign core_in_TDATA   = r_blk;
    assign core_key        = r_key;
    assign core_out_TREADY = (r_state == RUN) & ~r_res_seen;

    assign w_out_hs  = core_out_TVALID & core_out_TREADY;
    assign w_rdy_now = r_rdy_seen | core_ap_ready;
    assign w_res_now = r_res_seen | w_out_hs;

    assign m0_TVALID = (r_state == DELIVER) & ~r_grant;
    assign m1_TVALID = (r_state == DELIVER) & r_grant;
    assign m0_TDATA  = r_res;
    assign m1_TDATA  = r_res;
    assign w_m_hs    = r_grant ? m1_TREADY : m0_TREADY;

    assign busy  = (r_state != IDLE);
    assign grant = r_grant;
    assign cnt0  = r_cnt0;
    assign cnt1  = r_cnt1;

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b1;
            r_grant      <= 1'b0;
            r_rdy_seen   <= 1'b0;
            r_res_seen   <= 1'b0;
            r_cnt0       <= '0;
            r_cnt1       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_take) begin
                        r_grant <= w_sel;
                        r_blk   <= w_sel ? s1_TDATA : s0_TDATA;
                        r_key   <= w_sel ? key1 : key0;
                        r_state <= SEND;
                    end
                end
                SEND: begin
                    if (core_in_TREADY) begin
                        r_rdy_seen <= 1'b0;
                        r_res_seen <= 1'b0;
                        r_state    <= RUN;
                    end
                end
                RUN: begin
                    // ap_ready and the result may land in either order or together.
                    if (core_ap_ready) begin
                        r_rdy_seen <= 1'b1;
                    end
                    if (w_out_hs) begin
                        r_res      <= core_out_TDATA;
                        r_res_seen <= 1'b1;
                    end
                    if (w_rdy_now & w_res_now) begin
                        r_state <= DELIVER;
                    end
                end
                DELIVER: begin
                    if (w_m_hs) begin
                        if (r_grant) begin
                            r_cnt1 <= r_cnt1 + CNT_ONE;
                        end else begin
                            r_cnt0 <= r_cnt0 + CNT_ONE;
                        end
                        r_last_grant <= r_grant;
                        r_state      <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes192dec_stream_arbiter.sv
// Scoreboard bench for aes192dec_stream_arbiter: channel drivers, a behavioural core with
// configurable ap_ready/result ordering, and a monitor that checks every delivered block.
module tb_aes192dec_stream_arbiter;

    localparam int DW = 128;
    localparam int KW = 192;
    localparam int CNTW = 32;

    localparam logic [191:0] FIPS_KEY = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
    localparam logic [127:0] FIPS_CT  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [191:0] KEY_B    = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    localparam logic [191:0] KEY_C    = 192'hffeeddccbbaa99887766554433221100f0e1d2c3b4a59687;

    logic            ap_clk = 1'b0;
    logic            ap_rst;
    logic [DW-1:0]   s0_TDATA, s1_TDATA, m0_TDATA, m1_TDATA;
    logic            s0_TVALID, s0_TREADY, s1_TVALID, s1_TREADY;
    logic [KW-1:0]   key0, key1, core_key;
    logic            m0_TVALID, m0_TREADY, m1_TVALID, m1_TREADY;
    logic            core_ap_start, core_ap_ready, core_ap_idle;
    logic [DW-1:0]   core_in_TDATA, core_out_TDATA;
    logic            core_in_TVALID, core_in_TREADY, core_out_TVALID, core_out_TREADY;
    logic            busy, grant;
    logic [CNTW-1:0] cnt0, cnt1;

    always #5 ap_clk = ~ap_clk;

    aes192dec_stream_arbiter #(.DW(DW), .KW(KW), .CNTW(CNTW)) dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst),
        .s0_TDATA(s0_TDATA), .s0_TVALID(s0_TVALID), .s0_TREADY(s0_TREADY),
        .s1_TDATA(s1_TDATA), .s1_TVALID(s1_TVALID), .s1_TREADY(s1_TREADY),
        .key0(key0), .key1(key1),
        .m0_TDATA(m0_TDATA), .m0_TVALID(m0_TVALID), .m0_TREADY(m0_TREADY),
        .m1_TDATA(m1_TDATA), .m1_TVALID(m1_TVALID), .m1_TREADY(m1_TREADY),
        .core_ap_start(core_ap_start), .core_ap_ready(core_ap_ready), .core_ap_idle(core_ap_idle),
        .core_in_TDATA(core_in_TDATA), .core_in_TVALID(core_in_TVALID), .core_in_TREADY(core_in_TREADY),
        .core_key(core_key),
        .core_out_TDATA(core_out_TDATA), .core_out_TVALID(core_out_TVALID), .core_out_TREADY(core_out_TREADY),
        .busy(busy), .grant(grant), .cnt0(cnt0), .cnt1(cnt1)
    );

    typedef struct {
        logic [127:0] d;
        logic [191:0] k;
    } blk_t;

    blk_t         q0[$];
    blk_t         q1[$];
    logic [127:0] exp0[$];
    logic [127:0] exp1[$];
    bit           exp_grant[$];
    int           n_cmp = 0;
    int           n_err = 0;
    int           cm_rdy_t = 2;
    int           cm_res_t = 3;
    bit           cm_rst_req = 1'b0;
    logic [191:0] key0_idle = FIPS_KEY;
    logic [191:0] key1_idle = KEY_B;

    task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Stand-in for the decrypt core: exact for the FIPS-197 vector, a keyed mix otherwise.
    function automatic logic [127:0] toy_dec(input logic [127:0] ct, input logic [191:0] k);
        if (ct == FIPS_CT && k == FIPS_KEY) return FIPS_PT;
        return ct ^ k[127:0] ^ k[191:64];
    endfunction

    task automatic issue(input bit ch, input logic [127:0] d, input logic [191:0] k,
                         input logic [127:0] pt);
        blk_t b;
        b.d = d;
        b.k = k;
        if (ch) begin
            q1.push_back(b);
            exp1.push_back(pt);
        end else begin
            q0.push_back(b);
            exp0.push_back(pt);
        end
    endtask

    task automatic grant_chk(input bit ch);
        if (exp_grant.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL grant_order: got accept on ch%0d required none", ch);
        end else begin
            check("grant_order", {191'd0, ch}, {191'd0, exp_grant.pop_front()});
        end
        $display("accept ch%0d", ch);
    endtask

    // Channel drivers: TVALID held while the queue is non-empty, popped on handshake.
    initial begin
        s0_TVALID = 1'b0;
        s0_TDATA  = '0;
        key0      = FIPS_KEY;
        forever begin
            @(negedge ap_clk);
            if (q0.size() > 0) begin
                s0_TVALID = 1'b1;
                s0_TDATA  = q0[0].d;
                key0      = q0[0].k;
            end else begin
                s0_TVALID = 1'b0;
                key0      = key0_idle;
            end
            #1;
            if (s0_TVALID && s0_TREADY) begin
                void'(q0.pop_front());
                grant_chk(1'b0);
            end
        end
    end

    initial begin
        s1_TVALID = 1'b0;
        s1_TDATA  = '0;
        key1      = KEY_B;
        forever begin
            @(negedge ap_clk);
            if (q1.size() > 0) begin
                s1_TVALID = 1'b1;
                s1_TDATA  = q1[0].d;
                key1      = q1[0].k;
            end else begin
                s1_TVALID = 1'b0;
                key1      = key1_idle;
            end
            #1;
            if (s1_TVALID && s1_TREADY) begin
                void'(q1.pop_front());
                grant_chk(1'b1);
            end
        end
    end

    // Core model: ap_ready pulses at cm_rdy_t, result offered from cm_res_t (cycles after accept).
    initial begin
        int           t = 0;
        bit           busy_m = 1'b0, rdy_done = 1'b0, res_done = 1'b0, out_hs = 1'b0, chk_start = 1'b0;
        logic [127:0] blk = '0;
        core_in_TREADY  = 1'b0;
        core_ap_ready   = 1'b0;
        core_ap_idle    = 1'b1;
        core_out_TVALID = 1'b0;
        core_out_TDATA  = '0;
        forever begin
            @(negedge ap_clk);
            core_ap_ready = 1'b0;
            if (chk_start) begin
                check("start_drop_after_ready", {191'd0, core_ap_start}, 192'd0);
                chk_start = 1'b0;
            end
            if (cm_rst_req) begin
                busy_m = 1'b0; out_hs = 1'b0; chk_start = 1'b0;
                core_out_TVALID = 1'b0;
                core_in_TREADY  = 1'b0;
                core_ap_idle    = 1'b1;
                cm_rst_req      = 1'b0;
            end else if (!busy_m) begin
                core_in_TREADY = 1'b1;
                core_ap_idle   = 1'b1;
                if (core_in_TVALID) begin
                    blk = core_in_TDATA;
                    busy_m = 1'b1; t = 0; rdy_done = 1'b0; res_done = 1'b0; out_hs = 1'b0;
                end
            end else begin
                core_in_TREADY = 1'b0;
                core_ap_idle   = 1'b0;
                t++;
                if (out_hs) begin
                    core_out_TVALID = 1'b0;
                    res_done = 1'b1;
                    out_hs = 1'b0;
                end
                if (t == cm_rdy_t) begin
                    check("start_before_ready", {191'd0, core_ap_start}, 192'd1);
                    core_ap_ready = 1'b1;
                    rdy_done = 1'b1;
                    chk_start = 1'b1;
                end
                if (t == cm_res_t) begin
                    core_out_TVALID = 1'b1;
                    core_out_TDATA  = toy_dec(blk, core_key);
                end
                if (core_out_TVALID && core_out_TREADY) out_hs = 1'b1;
                if (rdy_done && res_done) busy_m = 1'b0;
            end
        end
    end

    // Monitor: pops the scoreboard on every m* handshake and checks hold-while-stalled.
    initial begin
        logic [127:0] pd0 = '0, pd1 = '0;
        bit           pv0 = 1'b0, pv1 = 1'b0;
        forever begin
            @(negedge ap_clk);
            #2;
            if (ap_rst) begin
                pv0 = 1'b0;
                pv1 = 1'b0;
                continue;
            end
            if (m0_TVALID || m1_TVALID)
                check("m_valid_onehot", {190'd0, m1_TVALID, m0_TVALID}, grant ? 192'd2 : 192'd1);
            if (pv0) check("m0_hold", {63'd0, m0_TVALID, m0_TDATA}, {63'd0, 1'b1, pd0});
            if (pv1) check("m1_hold", {63'd0, m1_TVALID, m1_TDATA}, {63'd0, 1'b1, pd1});
            pv0 = m0_TVALID && !m0_TREADY;
            pv1 = m1_TVALID && !m1_TREADY;
            pd0 = m0_TDATA;
            pd1 = m1_TDATA;
            if (m0_TVALID && m0_TREADY) begin
                $display("deliver m0 %h", m0_TDATA);
                if (exp0.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL m0_unexpected: got %h required no transfer", m0_TDATA);
                end else check("m0_data", {64'd0, m0_TDATA}, {64'd0, exp0.pop_front()});
            end
            if (m1_TVALID && m1_TREADY) begin
                $display("deliver m1 %h", m1_TDATA);
                if (exp1.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL m1_unexpected: got %h required no transfer", m1_TDATA);
                end else check("m1_data", {64'd0, m1_TDATA}, {64'd0, exp1.pop_front()});
            end
        end
    end

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        bit done = 1'b0;
        while (!done && n < budget) begin
            @(negedge ap_clk);
            #3;
            n++;
            done = !busy && q0.size() == 0 && q1.size() == 0 && exp0.size() == 0 && exp1.size() == 0;
        end
        check({name, "_completes"}, {191'd0, done}, 192'd1);
    endtask

    task automatic wait_sig(input string name, input int sel, input int budget);
        int n = 0;
        bit hit = 1'b0;
        while (!hit && n < budget) begin
            @(negedge ap_clk);
            #3;
            n++;
            hit = (sel == 0) ? busy : m1_TVALID;
        end
        check({name, "_reached"}, {191'd0, hit}, 192'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        m0_TREADY = 1'b1;
        m1_TREADY = 1'b1;
        ap_rst = 1'b1;
        cm_rst_req = 1'b1;
        repeat (3) @(negedge ap_clk);
        #3;
        check("reset_status", {186'd0, busy, s0_TREADY, s1_TREADY, m0_TVALID, m1_TVALID, core_ap_start}, 192'd0);
        check("reset_core_if", {190'd0, core_in_TVALID, core_out_TREADY}, 192'd0);
        check("reset_cnt", {128'd0, cnt1, cnt0}, 192'd0);
        @(negedge ap_clk);
        ap_rst = 1'b0;

        // Single FIPS-197 block on channel 0.
        exp_grant.push_back(1'b0);
        issue(1'b0, FIPS_CT, FIPS_KEY, FIPS_PT);
        wait_idle("single", 200);
        check("single_cnt", {128'd0, cnt1, cnt0}, {128'd0, 32'd0, 32'd1});

        // Core ordering variants: result before / with / after ap_ready.
        cm_rdy_t = 4; cm_res_t = 1;
        exp_grant.push_back(1'b1);
        issue(1'b1, 128'h0123456789abcdeffedcba9876543210, KEY_B, toy_dec(128'h0123456789abcdeffedcba9876543210, KEY_B));
        wait_idle("variant_a", 200);
        cm_rdy_t = 2; cm_res_t = 2;
        exp_grant.push_back(1'b0);
        issue(1'b0, 128'h55aa55aa00ff00ff1234123456785678, KEY_B, toy_dec(128'h55aa55aa00ff00ff1234123456785678, KEY_B));
        wait_idle("variant_b", 200);
        cm_rdy_t = 1; cm_res_t = 3;
        exp_grant.push_back(1'b1);
        issue(1'b1, 128'hdeadbeefcafef00d0badc0de8badf00d, KEY_B, toy_dec(128'hdeadbeefcafef00d0badc0de8badf00d, KEY_B));
        wait_idle("variant_c", 200);
        check("variant_cnt", {128'd0, cnt1, cnt0}, {128'd0, 32'd2, 32'd2});

        // Both channels continuously valid: grants alternate starting with channel 0.
        cm_rdy_t = 2; cm_res_t = 3;
        for (int i = 0; i < 4; i++) begin
            logic [127:0] d0, d1;
            d0 = {4{32'h0a000000 + 32'(i)}};
            d1 = {4{32'hb0000000 + 32'(i)}};
            exp_grant.push_back(1'b0);
            exp_grant.push_back(1'b1);
            issue(1'b0, d0, KEY_B, toy_dec(d0, KEY_B));
            issue(1'b1, d1, KEY_B, toy_dec(d1, KEY_B));
        end
        wait_idle("fair8", 1000);
        check("fair8_cnt", {128'd0, cnt1, cnt0}, {128'd0, 32'd6, 32'd6});

        // Back-pressure on m1 while channel 0 waits.
        m1_TREADY = 1'b0;
        exp_grant.push_back(1'b1);
        exp_grant.push_back(1'b0);
        issue(1'b1, 128'h11112222333344445555666677778888, KEY_B, toy_dec(128'h11112222333344445555666677778888, KEY_B));
        wait_sig("bp_busy", 0, 50);
        issue(1'b0, 128'h99990000aaaabbbbccccddddeeeeffff, KEY_B, toy_dec(128'h99990000aaaabbbbccccddddeeeeffff, KEY_B));
        wait_sig("bp_deliver", 1, 100);
        for (int i = 0; i < 50; i++) begin
            @(negedge ap_clk);
            #3;
            check("bp_hold_ready_start_valid", {189'd0, s0_TREADY, core_ap_start, m1_TVALID}, 192'd1);
        end
        @(negedge ap_clk);
        m1_TREADY = 1'b1;
        wait_idle("bp", 300);
        check("bp_cnt", {128'd0, cnt1, cnt0}, {128'd0, 32'd7, 32'd7});

        // Key change on key1 during RUN must not reach the core.
        cm_rdy_t = 6; cm_res_t = 6;
        exp_grant.push_back(1'b1);
        issue(1'b1, 128'hfeedfacefeedfacefeedfacefeedface, KEY_B, toy_dec(128'hfeedfacefeedfacefeedfacefeedface, KEY_B));
        wait_sig("key_busy", 0, 50);
        repeat (2) @(negedge ap_clk);
        key1_idle = KEY_C;
        repeat (2) begin
            @(negedge ap_clk);
            #3;
            check("key_hold", core_key, KEY_B);
        end
        wait_idle("keychg", 200);
        check("keychg_cnt", {128'd0, cnt1, cnt0}, {128'd0, 32'd8, 32'd7});

        // Reset during RUN abandons the block and restores channel-0 priority.
        cm_rdy_t = 20; cm_res_t = 20;
        exp_grant.push_back(1'b0);
        issue(1'b0, 128'h0f0e0d0c0b0a09080706050403020100, KEY_B, 128'h0);
        wait_sig("rst_busy", 0, 50);
        repeat (4) @(negedge ap_clk);
        ap_rst = 1'b1;
        cm_rst_req = 1'b1;
        @(negedge ap_clk);
        ap_rst = 1'b0;
        exp0.delete();
        #3;
        check("rst_status", {189'd0, busy, m0_TVALID, m1_TVALID}, 192'd0);
        check("rst_cnt", {128'd0, cnt1, cnt0}, 192'd0);
        repeat (5) begin
            @(negedge ap_clk);
            #3;
            check("rst_quiet", {189'd0, busy, m0_TVALID, m1_TVALID}, 192'd0);
        end
        cm_rdy_t = 2; cm_res_t = 3;
        exp_grant.push_back(1'b0);
        exp_grant.push_back(1'b1);
        issue(1'b1, 128'h1234567890abcdef1234567890abcdef, KEY_C, toy_dec(128'h1234567890abcdef1234567890abcdef, KEY_C));
        issue(1'b0, 128'hcafebabecafebabecafebabecafebabe, KEY_C, toy_dec(128'hcafebabecafebabecafebabecafebabe, KEY_C));
        wait_idle("post_rst", 300);
        check("post_rst_cnt", {128'd0, cnt1, cnt0}, {128'd0, 32'd1, 32'd1});
        check("grant_queue_drained", {160'd0, 32'(exp_grant.size())}, 192'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
